// File: rtl/demux_1to4_b32_pkg.sv
// demux_1to4_b32_pkg: shared defaults and types for the buffered 1-to-4 demultiplexer
//   DEF_WIDTH : default data word width
//   DEF_DEPTH : default entries per channel FIFO (power of two, >= 2)
//   PTR_W     : pointer width for the default depth
//   sel_t     : 2-bit destination select {C1,C0}
//   word_t    : data word at the default width
package demux_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 2;
    localparam int PTR_W     = $clog2(DEF_DEPTH);
    typedef logic [1:0]           sel_t;
    typedef logic [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/demux_1to4_b32_chan_fifo.sv
// chan_fifo: per-channel FIFO with a zero-gated head word
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears pointers, count and storage
//   push  : write din this cycle (ignored when full)
//   din   : word to write
//   full  : count == DEPTH
//   pop   : consumer takes the head this cycle (ignored when empty)
//   dout  : head word, forced to 0 when empty
//   valid : count != 0
module chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_FULL);
    assign valid  = (r_count != '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & valid;
    assign dout   = valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            // simultaneous push and pop leaves the count unchanged
            if (w_push & ~w_pop) r_count <= r_count + CNT_ONE;
            else if (w_pop & ~w_push) r_count <= r_count - CNT_ONE;
        end
    end
endmodule

// File: rtl/demux_1to4_b32.sv
// demux_1to4_b32: buffered 1-to-4 demultiplexer steering a valid/ready word stream into four channel FIFOs
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   C1, C0   : destination select {C1,C0}, sampled when in_valid=1
//   in_valid : producer has a word on I
//   in_ready : selected channel is not full (independent of in_valid)
//   I        : input word
//   o_valid  : bit k set when channel k has a word on Ok
//   o_ready  : bit k set when consumer k takes Ok
//   O0..O3   : channel head words, 0 when the channel is empty
module demux_1to4_b32
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             C1,
    input  logic             C0,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] I,
    output logic [3:0]       o_valid,
    input  logic [3:0]       o_ready,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3
);
    sel_t             w_sel;
    logic [3:0]       w_full;
    logic [3:0]       w_push;
    logic [WIDTH-1:0] w_dout [4];

    assign w_sel    = {C1, C0};
    // no bypass: a full channel stays not-ready even if its consumer pops this cycle
    assign in_ready = ~w_full[w_sel];
    assign w_push   = (in_valid & in_ready) ? (4'b0001 << w_sel) : 4'b0000;

    for (genvar k = 0; k < 4; k++) begin : g_chan
        chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (w_push[k]),
            .din   (I),
            .full  (w_full[k]),
            .pop   (o_ready[k]),
            .dout  (w_dout[k]),
            .valid (o_valid[k])
        );
    end

    assign O0 = w_dout[0];
    assign O1 = w_dout[1];
    assign O2 = w_dout[2];
    assign O3 = w_dout[3];
endmodule

// File: tb/tb_demux_1to4_b32.sv
// tb_demux_1to4_b32: directed vector table plus randomized queue-model checking of demux_1to4_b32
module tb_demux_1to4_b32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        C1 = 1'b0, C0 = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] I = '0;
    logic [3:0]  o_valid;
    logic [3:0]  o_ready = '0;
    logic [31:0] O0, O1, O2, O3;
    logic [31:0] o_arr [4];

    int checks = 0;
    int errors = 0;
    logic [31:0] q [4][$];

    demux_1to4_b32 #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .C1(C1), .C0(C0),
        .in_valid(in_valid), .in_ready(in_ready), .I(I),
        .o_valid(o_valid), .o_ready(o_ready),
        .O0(O0), .O1(O1), .O2(O2), .O3(O3)
    );

    assign o_arr[0] = O0;
    assign o_arr[1] = O1;
    assign o_arr[2] = O2;
    assign o_arr[3] = O3;

    always #5 clk = ~clk;

    typedef struct packed {
        logic             v;
        logic [1:0]       s;
        logic [31:0]      d;
        logic [3:0]       r;
        logic             e_ir;
        logic [3:0]       e_ov;
        logic [3:0][31:0] e_o;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(logic v, logic [1:0] s, logic [31:0] d, logic [3:0] r,
                                logic ir, logic [3:0] ov,
                                logic [31:0] o0, logic [31:0] o1, logic [31:0] o2, logic [31:0] o3);
        vec_t x;
        x.v = v; x.s = s; x.d = d; x.r = r; x.e_ir = ir; x.e_ov = ov;
        x.e_o[0] = o0; x.e_o[1] = o1; x.e_o[2] = o2; x.e_o[3] = o3;
        return x;
    endfunction

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        in_valid = v;
        {C1, C0} = s;
        I = d;
        o_ready = r;
        #1;
    endtask

    // advance the reference queues by the handshakes seen at the coming edge, then clock
    task automatic tick();
        logic [1:0] s;
        bit acc;
        s = {C1, C0};
        acc = in_valid && (q[s].size() < DEPTH);
        for (int k = 0; k < 4; k++)
            if (o_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
        if (acc) q[s].push_back(I);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        logic [1:0] s;
        s = {C1, C0};
        chk({tag, " in_ready"}, 32'(in_ready), 32'(q[s].size() < DEPTH));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s o_valid[%0d]", tag, k), 32'(o_valid[k]), 32'(q[k].size() != 0));
            chk($sformatf("%s O%0d", tag, k), o_arr[k], q[k].size() != 0 ? q[k][0] : 32'h0);
        end
    endtask

    task automatic cmp_idle(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 32'h1);
        chk({tag, " o_valid"}, 32'(o_valid), 32'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("%s O%0d", tag, k), o_arr[k], 32'h0);
    endtask

    initial begin
        vt[0]  = mk(1, 2, 32'hDEADBEEF, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        vt[1]  = mk(0, 2, 32'h0,        4'b0000, 1, 4'b0100, 0, 0, 32'hDEADBEEF, 0);
        vt[2]  = mk(0, 2, 32'h0,        4'b0100, 1, 4'b0100, 0, 0, 32'hDEADBEEF, 0);
        vt[3]  = mk(0, 2, 32'h0,        4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        vt[4]  = mk(1, 1, 32'hA1,       4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        vt[5]  = mk(1, 1, 32'hA2,       4'b0000, 1, 4'b0010, 0, 32'hA1, 0, 0);
        vt[6]  = mk(0, 1, 32'h0,        4'b0000, 0, 4'b0010, 0, 32'hA1, 0, 0);
        vt[7]  = mk(1, 0, 32'hA3,       4'b0000, 1, 4'b0010, 0, 32'hA1, 0, 0);
        vt[8]  = mk(0, 1, 32'h0,        4'b0000, 0, 4'b0011, 32'hA3, 32'hA1, 0, 0);
        vt[9]  = mk(1, 3, 32'hB1,       4'b0000, 1, 4'b0011, 32'hA3, 32'hA1, 0, 0);
        vt[10] = mk(1, 3, 32'hB2,       4'b0000, 1, 4'b1011, 32'hA3, 32'hA1, 0, 32'hB1);
        vt[11] = mk(1, 3, 32'hB3,       4'b1000, 0, 4'b1011, 32'hA3, 32'hA1, 0, 32'hB1);
        vt[12] = mk(1, 3, 32'hB3,       4'b0000, 1, 4'b1011, 32'hA3, 32'hA1, 0, 32'hB2);
        vt[13] = mk(0, 3, 32'h0,        4'b1000, 0, 4'b1011, 32'hA3, 32'hA1, 0, 32'hB2);
        vt[14] = mk(0, 3, 32'h0,        4'b1000, 1, 4'b1011, 32'hA3, 32'hA1, 0, 32'hB3);
        vt[15] = mk(0, 3, 32'h0,        4'b0011, 1, 4'b0011, 32'hA3, 32'hA1, 0, 0);
        vt[16] = mk(1, 0, 32'hC1,       4'b0010, 1, 4'b0010, 0, 32'hA2, 0, 0);
        vt[17] = mk(1, 0, 32'hC2,       4'b0001, 1, 4'b0001, 32'hC1, 0, 0, 0);
        vt[18] = mk(0, 0, 32'h0,        4'b0000, 1, 4'b0001, 32'hC2, 0, 0, 0);

        #1;
        cmp_idle("in reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cmp_idle("after reset");

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].v, vt[i].s, vt[i].d, vt[i].r);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
            chk($sformatf("vec%0d o_valid", i), 32'(o_valid), 32'(vt[i].e_ov));
            for (int k = 0; k < 4; k++)
                chk($sformatf("vec%0d O%0d", i, k), o_arr[k], vt[i].e_o[k]);
            tick();
        end

        drive(1, 2, 32'h5555_AAAA, 4'b0000);
        tick();
        drive(0, 2, 32'h0, 4'b0000);
        chk("pre-reset o_valid[2]", 32'(o_valid[2]), 32'h1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) q[k].delete();
        cmp_idle("async reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cmp_idle("post reset release");

        for (int i = 0; i < 100; i++) begin
            drive(1, 2'(i % 4), $urandom, 4'b1111);
            chk($sformatf("stream%0d stall", i), 32'(in_ready), 32'h1);
            cmp_model($sformatf("stream%0d", i));
            tick();
        end

        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)));
            cmp_model($sformatf("rand%0d", i));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
